// File: rtl/serial_pattern_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_pattern_ctrl_if
// Configuration bus for serial_pattern_ctrl. A transfer happens on a clock
// edge where cfg_valid && cfg_ready.
//   cfg_valid   : master -> slave, config request
//   cfg_ready   : slave -> master, controller can take a config
//   cfg_pattern : pattern bits, bit [cfg_len-1] is received first
//   cfg_len     : pattern length, legal range 1..MAX_LEN
//   cfg_overlap : 1 = overlapping matches allowed
//   cfg_target  : matches needed to finish a run, 0 = unlimited
// ---------------------------------------------------------------------------
interface serial_pattern_ctrl_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) ();
    logic               cfg_valid;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        output cfg_ready
    );
endinterface

// File: rtl/serial_pattern_ctrl.sv
// ---------------------------------------------------------------------------
// serial_pattern_ctrl
// Programmable serial bit-pattern detector. A pattern, its length, overlap
// mode and match target are loaded over the cfg interface; start arms a run
// that shifts in bits whenever inp_valid is high and counts matches. The run
// ends in DONE once the target count is reached, or returns to CFG on abort.
//
// Ports:
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   cfg          : configuration bus (slave side)
//   start, abort : one-cycle run control pulses
//   inp          : serial data bit, sampled only when inp_valid is high
//   match        : one-cycle pulse, registered, the cycle after the final bit
//   match_count  : matches counted in the current run, saturating
//   busy / done  : high in RUN / DONE
//   err          : one-cycle pulse on an illegal config or a start in IDLE
// ---------------------------------------------------------------------------
module serial_pattern_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_pattern_ctrl_if.slave cfg,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 inp,
    input  logic                 inp_valid,
    output logic                 match,
    output logic [CNT_W-1:0]     match_count,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,   // no valid config yet
        S_CFG  = 2'd1,   // configured, not running
        S_RUN  = 2'd2,   // detecting
        S_DONE = 2'd3    // target reached, results held
    } state_e;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    state_e             state_q,   state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q,     len_d;
    logic               overlap_q, overlap_d;
    logic [CNT_W-1:0]   target_q,  target_d;
    logic [MAX_LEN-1:0] hist_q,    hist_d;
    logic [LEN_W-1:0]   seen_q,    seen_d;
    logic               match_q,   match_d;
    logic [CNT_W-1:0]   count_q,   count_d;
    logic               err_q,     err_d;

    logic               cfg_fire;
    logic               cfg_legal;
    logic [MAX_LEN-1:0] len_mask;
    logic [MAX_LEN-1:0] hist_next;
    logic [LEN_W-1:0]   seen_next;
    logic               hit;

    assign cfg.cfg_ready = (state_q != S_RUN);
    assign cfg_fire      = cfg.cfg_valid && cfg.cfg_ready;
    assign cfg_legal     = (cfg.cfg_len != '0) && (cfg.cfg_len <= LEN_MAX);

    // History and fill level as they would be after shifting in inp. A match
    // needs the low len bits to equal the pattern and at least len bits seen
    // since the run started (or since the last match when overlap is off).
    always_comb begin
        hist_next = {hist_q[MAX_LEN-2:0], inp};
        seen_next = (seen_q == LEN_MAX) ? seen_q : seen_q + 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
        hit = ((hist_next & len_mask) == (pattern_q & len_mask)) && (seen_next >= len_q);
    end

    always_comb begin
        // NOTE: every _d takes its hold value (or pulse default) first so no
        // path through the decision tree leaves it unassigned and infers a latch.
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        target_d  = target_q;
        hist_d    = hist_q;
        seen_d    = seen_q;
        count_d   = count_q;
        match_d   = 1'b0;
        err_d     = 1'b0;

        if (cfg_fire) begin
            // A config transfer takes priority over a simultaneous start.
            if (cfg_legal) begin
                pattern_d = cfg.cfg_pattern;
                len_d     = cfg.cfg_len;
                overlap_d = cfg.cfg_overlap;
                target_d  = cfg.cfg_target;
                count_d   = '0;
                state_d   = S_CFG;
            end else begin
                err_d = 1'b1;
            end
        end else if (start && (state_q != S_RUN)) begin
            if (state_q == S_IDLE) begin
                err_d = 1'b1;
            end else begin
                hist_d  = '0;
                seen_d  = '0;
                count_d = '0;
                state_d = S_RUN;
            end
        end else if (state_q == S_RUN) begin
            if (abort) begin
                // Abort suppresses any match completing on this cycle.
                state_d = S_CFG;
            end else if (inp_valid) begin
                hist_d = hist_next;
                seen_d = seen_next;
                if (hit) begin
                    match_d = 1'b1;
                    if (count_q != '1) begin
                        count_d = count_q + 1'b1;
                    end
                    if (!overlap_q) begin
                        seen_d = '0;
                    end
                    if ((target_q != '0) && ((count_q + 1'b1) == target_q)) begin
                        state_d = S_DONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= S_IDLE;
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            target_q  <= '0;
            hist_q    <= '0;
            seen_q    <= '0;
            count_q   <= '0;
            match_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            target_q  <= target_d;
            hist_q    <= hist_d;
            seen_q    <= seen_d;
            count_q   <= count_d;
            match_q   <= match_d;
            err_q     <= err_d;
        end
    end

    assign match       = match_q;
    assign match_count = count_q;
    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign err         = err_q;

endmodule

// File: tb/tb_serial_pattern_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_pattern_ctrl
// Directed scenarios with literal expectations, followed by a randomized
// phase. A behavioural model (queue of received bits, integer counters)
// predicts every output, and a compare process checks it each cycle.
// ---------------------------------------------------------------------------
module tb_serial_pattern_ctrl;
    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 8;

    logic clk;
    logic rst;
    logic start;
    logic abort;
    logic inp;
    logic inp_valid;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             busy;
    logic             done;
    logic             err;

    serial_pattern_ctrl_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) cfg_if ();

    serial_pattern_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg         (cfg_if),
        .start       (start),
        .abort       (abort),
        .inp         (inp),
        .inp_valid   (inp_valid),
        .match       (match),
        .match_count (match_count),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_CFG, M_RUN, M_DONE} mstate_e;
    mstate_e m_st;
    int  m_pat, m_len, m_ovl, m_tgt, m_cnt;
    bit  m_match, m_err;
    bit  m_bits[$];        // bits eligible to form the next match, oldest first
    bit  model_ok = 1'b0;

    // Value of the newest n bits, first-received bit as MSB.
    function automatic int tail_value(input int n);
        int v = 0;
        for (int i = m_bits.size() - n; i < m_bits.size(); i++) v = (v << 1) | int'(m_bits[i]);
        return v;
    endfunction

    always @(posedge clk) begin
        m_match = 1'b0;
        m_err   = 1'b0;
        if (rst) begin
            m_st = M_IDLE;
            m_pat = 0; m_len = 0; m_ovl = 0; m_tgt = 0; m_cnt = 0;
            m_bits.delete();
            model_ok = 1'b1;
        end else if (cfg_if.cfg_valid && m_st != M_RUN) begin
            if (int'(cfg_if.cfg_len) >= 1 && int'(cfg_if.cfg_len) <= MAX_LEN) begin
                m_pat = int'(cfg_if.cfg_pattern);
                m_len = int'(cfg_if.cfg_len);
                m_ovl = int'(cfg_if.cfg_overlap);
                m_tgt = int'(cfg_if.cfg_target);
                m_cnt = 0;
                m_st  = M_CFG;
            end else begin
                m_err = 1'b1;
            end
        end else if (start && m_st != M_RUN) begin
            if (m_st == M_IDLE) m_err = 1'b1;
            else begin
                m_st = M_RUN;
                m_cnt = 0;
                m_bits.delete();
            end
        end else if (m_st == M_RUN) begin
            if (abort) m_st = M_CFG;
            else if (inp_valid) begin
                m_bits.push_back(inp);
                if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
                if (m_bits.size() >= m_len && tail_value(m_len) == (m_pat & ((1 << m_len) - 1))) begin
                    m_match = 1'b1;
                    if (m_ovl == 0) m_bits.delete();
                    if (m_tgt != 0 && m_cnt + 1 == m_tgt) m_st = M_DONE;
                    if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("cmp_match",     32'(match),       32'(m_match));
            check("cmp_count",     32'(match_count), 32'(m_cnt));
            check("cmp_busy",      32'(busy),        32'(m_st == M_RUN));
            check("cmp_done",      32'(done),        32'(m_st == M_DONE));
            check("cmp_err",       32'(err),         32'(m_err));
            check("cmp_cfg_ready", 32'(cfg_if.cfg_ready), 32'(m_st != M_RUN));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_cfg(input logic [7:0] pat, input int len, input bit ovl, input int tgt);
        cfg_if.cfg_valid   = 1'b1;
        cfg_if.cfg_pattern = pat;
        cfg_if.cfg_len     = LEN_W'(len);
        cfg_if.cfg_overlap = ovl;
        cfg_if.cfg_target  = CNT_W'(tgt);
        cyc();
        cfg_if.cfg_valid   = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1; cyc(); abort = 1'b0;
    endtask

    task automatic send_bit(input bit b);
        inp = b; inp_valid = 1'b1; cyc(); inp_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; inp = 1'b0; inp_valid = 1'b0;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_pattern = '0; cfg_if.cfg_len = '0;
        cfg_if.cfg_overlap = 1'b0; cfg_if.cfg_target = '0;
        cyc(); cyc();
        rst = 1'b0;
        check("rst_cfg_ready", 32'(cfg_if.cfg_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_count", 32'(match_count), 0);

        // Illegal configs and start in IDLE
        do_cfg(8'h05, 0, 1'b1, 0);
        check("len0_err", 32'(err), 1);
        cyc();
        check("err_pulse_one_cycle", 32'(err), 0);
        do_cfg(8'h05, 9, 1'b1, 0);
        check("len9_err", 32'(err), 1);
        do_start();
        check("start_idle_err", 32'(err), 1);
        check("start_idle_busy", 32'(busy), 0);

        // 110 detector, overlap, unlimited
        do_cfg(8'b110, 3, 1'b1, 0);
        do_start();
        check("t1_busy", 32'(busy), 1);
        send_bit(1); send_bit(1);
        check("t1_no_match_b2", 32'(match), 0);
        send_bit(0);
        check("t1_match_b3", 32'(match), 1);
        send_bit(1);
        check("t1_match_low_b4", 32'(match), 0);
        send_bit(1); send_bit(0);
        check("t1_match_b6", 32'(match), 1);
        check("t1_count", 32'(match_count), 2);
        do_abort();

        // 1010, overlap then no overlap
        do_cfg(8'b1010, 4, 1'b1, 0);
        do_start();
        send_bit(1); send_bit(0); send_bit(1); send_bit(0);
        check("t2o_match_b4", 32'(match), 1);
        send_bit(1); send_bit(0);
        check("t2o_match_b6", 32'(match), 1);
        check("t2o_count", 32'(match_count), 2);
        do_abort();
        do_cfg(8'b1010, 4, 1'b0, 0);
        do_start();
        send_bit(1); send_bit(0); send_bit(1); send_bit(0);
        send_bit(1); send_bit(0);
        check("t2n_no_match_b6", 32'(match), 0);
        check("t2n_count", 32'(match_count), 1);
        do_abort();

        // 11 with target 3
        do_cfg(8'b11, 2, 1'b1, 3);
        do_start();
        send_bit(1); send_bit(1); send_bit(1);
        check("t3_count_b3", 32'(match_count), 2);
        send_bit(1);
        check("t3_match_b4", 32'(match), 1);
        check("t3_done", 32'(done), 1);
        check("t3_busy", 32'(busy), 0);
        send_bit(1);
        check("t3_b5_ignored", 32'(match), 0);
        check("t3_count_held", 32'(match_count), 3);

        // Gaps in inp_valid, then abort colliding with a match
        do_cfg(8'b110, 3, 1'b1, 0);
        check("t5_cfg_clears_done", 32'(done), 0);
        check("t5_cfg_clears_count", 32'(match_count), 0);
        do_start();
        send_bit(1); send_bit(1);
        inp = 1'b1;
        repeat (5) cyc();
        send_bit(0);
        check("t5_gap_match", 32'(match), 1);
        do_abort();
        do_start();
        send_bit(1); send_bit(1); send_bit(0);
        send_bit(1); send_bit(1);
        abort = 1'b1; send_bit(0); abort = 1'b0;
        check("t5_abort_no_match", 32'(match), 0);
        check("t5_abort_busy", 32'(busy), 0);
        check("t5_abort_count", 32'(match_count), 1);

        // Reset mid-run
        do_start();
        send_bit(1); send_bit(1); send_bit(0); send_bit(1); send_bit(1); send_bit(0);
        check("t6_count", 32'(match_count), 2);
        send_bit(1); send_bit(1);
        rst = 1'b1; send_bit(0); rst = 1'b0;
        check("t6_match", 32'(match), 0);
        check("t6_count_rst", 32'(match_count), 0);
        check("t6_cfg_ready", 32'(cfg_if.cfg_ready), 1);
        do_start();
        check("t6_start_err", 32'(err), 1);

        // len=1 and count saturation
        do_cfg(8'b1, 1, 1'b1, 0);
        do_start();
        send_bit(1);
        check("len1_match", 32'(match), 1);
        send_bit(0);
        check("len1_zero", 32'(match), 0);
        repeat (300) send_bit(1);
        check("sat_count", 32'(match_count), 255);
        check("sat_match", 32'(match), 1);
        do_abort();

        // Randomized phase
        for (int c = 0; c < 4000; c++) begin
            cfg_if.cfg_valid   = ($urandom_range(0, 29) == 0);
            cfg_if.cfg_pattern = MAX_LEN'($urandom);
            cfg_if.cfg_len     = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(0, 10))
                                                             : LEN_W'($urandom_range(1, 3));
            cfg_if.cfg_overlap = 1'($urandom_range(0, 1));
            cfg_if.cfg_target  = CNT_W'($urandom_range(0, 4));
            start     = ($urandom_range(0, 14) == 0);
            abort     = ($urandom_range(0, 79) == 0);
            rst       = ($urandom_range(0, 799) == 0);
            inp_valid = ($urandom_range(0, 3) != 0);
            inp       = 1'($urandom_range(0, 1));
            cyc();
        end
        cfg_if.cfg_valid = 1'b0; start = 1'b0; abort = 1'b0; rst = 1'b0; inp_valid = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/serial_pattern_ctrl.md
Name: serial_pattern_ctrl

Overview:
Programmable controller for serial bit-pattern detection. It replaces the fixed "110" Mealy detector with a sequenced, reconfigurable engine that:
- accepts a pattern, its length, an overlap mode and a match target through a ready/valid config port;
- arms detection on start and counts matches on a gated serial stream;
- reports completion when the target match count is reached.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..16)
LEN_W, 4, width of cfg_len; must hold MAX_LEN
CNT_W, 8, width of match target and match counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
cfg_valid  in  1  config request
cfg_ready  out  1  config accepted when cfg_valid && cfg_ready
cfg_pattern  in  MAX_LEN  pattern, bit [cfg_len-1] received first, bit 0 last
cfg_len  in  LEN_W  pattern length; legal range 1..MAX_LEN
cfg_overlap  in  1  1 = overlapping matches allowed
cfg_target  in  CNT_W  matches to reach done; 0 = unlimited
start  in  1  arm detection (one-cycle pulse)
abort  in  1  stop run (one-cycle pulse)
inp  in  1  serial data bit
inp_valid  in  1  inp sampled only when high
match  out  1  one-cycle pulse per detected match
match_count  out  CNT_W  matches counted in current run
busy  out  1  high in RUN
done  out  1  high in DONE
err  out  1  one-cycle pulse on illegal config or illegal start

Behaviour:
- Reset (sync, rst high at posedge):
  - state=IDLE; pattern, length, overlap and target registers cleared.
  - History register and bit counter cleared.
  - match=0, match_count=0, busy=0, done=0, err=0.
  - cfg_ready=1 on the first cycle after reset.
  - Reset during RUN abandons the run with no match pulse.
- States: IDLE (no valid config), CFG (configured, idle), RUN, DONE.
- cfg_ready is 1 in IDLE, CFG and DONE; 0 in RUN.
- Config handshake:
  - cfg_len in 1..MAX_LEN: registers loaded, state -> CFG, match_count and done cleared.
  - cfg_len = 0 or > MAX_LEN: err pulses next cycle, registers and state unchanged.
- Start:
  - In CFG or DONE: -> RUN; history, bit counter and match_count cleared; done cleared.
  - In IDLE: ignored, err pulses.
  - In RUN: ignored, no err.
  - cfg_valid and start in the same cycle in CFG/DONE: config is taken, start is ignored.
- RUN, on each cycle with inp_valid=1:
  - history <= {history[MAX_LEN-2:0], inp}.
  - seen <= min(seen+1, MAX_LEN).
  - Match condition: updated history[len-1:0] == pattern[len-1:0] and updated seen >= len.
- Match timing and effect:
  - Registered output: match is high the cycle after the completing bit is sampled.
  - match_count increments on the same edge match is set, saturating at all-ones.
  - Overlap=1: history and seen are kept after a match.
  - Overlap=0: seen is cleared to 0 after a match, so the next match needs len fresh bits.
- inp_valid=0: history, seen and match are unchanged; match stays 0.
- Target reached:
  - Condition: cfg_target != 0 and match_count+1 == cfg_target on a match.
  - Same edge: match pulses, count updates, state -> DONE, busy=0, done=1.
  - Bits after that edge are ignored.
- DONE: done held high and match_count held until start, cfg accept or rst.
- Abort:
  - In RUN: -> CFG next edge, busy=0, match_count held, done stays 0.
  - Abort wins over a match completing on the same cycle: no pulse, no increment.
  - Abort outside RUN: ignored.
- len=1: every sampled bit equal to pattern[0] matches, consecutively if overlap=1.
- Config registers are never modified during RUN.

Test Plan:
1. Reset, cfg pattern=3'b110, len=3, overlap=1, target=0, start; stream 1,1,0,1,1,0 (inp_valid=1) -> match pulses the cycle after bits 3 and 6; match_count=2; busy=1.
2. pattern=4'b1010, len=4: stream 1,0,1,0,1,0 -> overlap=1 gives 2 matches (after bits 4 and 6); overlap=0 gives 1 match.
3. pattern=2'b11, len=2, target=3, overlap=1: stream 1,1,1,1,1 -> matches after bits 2,3,4; done=1 and busy=0 with the third match; bit 5 ignored; count stays 3.
4. cfg_len=0 and cfg_len=9 (MAX_LEN=8) -> err pulse each time, state unchanged; start in IDLE after reset -> err pulse, busy stays 0.
5. Pattern 110 running; inp_valid low for 5 cycles between bits 2 and 3 -> match still detected after bit 3. Abort asserted on the cycle bit 3 completes a match in a new run -> no match pulse, state CFG, count unchanged.
6. rst asserted mid-RUN with match_count=2 -> next cycle all outputs 0 except cfg_ready=1; state IDLE; start now gives err.
